mem_resp: RTL and testbench

Block-granular backing-memory responder for the cache's memory port. Accepts one block read or block write request at a time from `cache_data`'s memory-side outputs and holds an internal block array. Completes each request after a fixed, parameterised latency with a one-cycle completion pulse. Replaces the zero-latency memory model so that cache miss, refill and write-back paths can be exercised under realistic stall conditions.

---
 rtl/mem_resp_if.sv | 22 ++
 rtl/mem_resp.sv | 101 ++++++++++
 tb/tb_mem_resp.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mem_resp_if.sv
// mem_resp_if: memory-port bundle between a block requester (master) and mem_resp (slave).
interface mem_resp_if #(
  parameter int PA_WIDTH  = 32,
  parameter int BLK_WIDTH = 512
);
  logic [PA_WIDTH-1:0]  mem_addr;
  logic                 mem_rd_en;
  logic                 mem_wr_en;
  logic [BLK_WIDTH-1:0] mem_wr_blk;
  logic [BLK_WIDTH-1:0] mem_rd_blk;
  logic                 rd_valid;
  logic                 wr_done;
  logic                 busy;
  modport master (
    output mem_addr, mem_rd_en, mem_wr_en, mem_wr_blk,
    input  mem_rd_blk, rd_valid, wr_done, busy
  );
  modport slave (
    input  mem_addr, mem_rd_en, mem_wr_en, mem_wr_blk,
    output mem_rd_blk, rd_valid, wr_done, busy
  );
endinterface

// File: rtl/mem_resp.sv
// mem_resp: fixed-latency block memory responder; define MEM_RESP_INIT_PATTERN_EN to
// start every 32-bit word holding its own byte address instead of zero.
module mem_resp #(
  parameter int PA_WIDTH  = 32,
  parameter int BLK_WIDTH = 512,
  parameter int MEM_DEPTH = 1024,
  parameter int RD_LAT    = 4,
  parameter int WR_LAT    = 6
) (
  input logic        clk,
  input logic        rst,
  mem_resp_if.slave  bus
);
  localparam int IW = $clog2(MEM_DEPTH);
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;
  state_t               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d, req_idx;
  logic [BLK_WIDTH-1:0] blk_q, blk_d, rd_blk_q, rd_blk_d, rd_data;
  logic                 rd_valid_q, rd_valid_d, wr_done_q, wr_done_d, we;
  logic [BLK_WIDTH-1:0] mem_q [MEM_DEPTH];
  // Per-block "written" flags give the array its time-0 contents without a clearing pass.
  logic [MEM_DEPTH-1:0] seen_q = '0;
  logic                 unused_addr;
  assign req_idx     = bus.mem_addr[6 +: IW];
  assign unused_addr = ^{bus.mem_addr[5:0], bus.mem_addr[PA_WIDTH-1:6+IW]};
`ifdef MEM_RESP_INIT_PATTERN_EN
  function automatic logic [BLK_WIDTH-1:0] pat(logic [IW-1:0] i);
    pat = '0;
    for (int w = 0; w < BLK_WIDTH / 32; w++) pat[w*32 +: 32] = 32'({i, 6'b0}) + 32'(w * 4);
  endfunction
  assign rd_data = seen_q[idx_q] ? mem_q[idx_q] : pat(idx_q);
`else
  assign rd_data = seen_q[idx_q] ? mem_q[idx_q] : '0;
`endif
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    blk_d      = blk_q;
    rd_blk_d   = rd_blk_q;
    rd_valid_d = 1'b0;
    wr_done_d  = 1'b0;
    we         = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.mem_wr_en) begin
          idx_d   = req_idx;
          blk_d   = bus.mem_wr_blk;
          cnt_d   = 8'(WR_LAT - 1);
          state_d = WR_WAIT;
        end else if (bus.mem_rd_en) begin
          idx_d   = req_idx;
          cnt_d   = 8'(RD_LAT - 1);
          state_d = RD_WAIT;
        end
      end
      RD_WAIT, WR_WAIT: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd0) begin
          cnt_d      = 8'd0;
          state_d    = DONE;
          rd_valid_d = state_q == RD_WAIT;
          wr_done_d  = state_q == WR_WAIT;
          we         = state_q == WR_WAIT;
          rd_blk_d   = state_q == RD_WAIT ? rd_data : rd_blk_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      blk_q      <= '0;
      rd_blk_q   <= '0;
      rd_valid_q <= 1'b0;
      wr_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      blk_q      <= blk_d;
      rd_blk_q   <= rd_blk_d;
      rd_valid_q <= rd_valid_d;
      wr_done_q  <= wr_done_d;
    end
  end
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[idx_q]  <= blk_q;
      seen_q[idx_q] <= 1'b1;
    end
  end
  assign bus.mem_rd_blk = rd_blk_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.wr_done    = wr_done_q;
  assign bus.busy       = state_q != IDLE;
endmodule

// File: tb/tb_mem_resp.sv
// tb_mem_resp: directed and randomized checks of mem_resp against an edge-count
// transaction model of the memory.
module tb_mem_resp;
  localparam int RD_LAT = 4;
  localparam int WR_LAT = 6;
  localparam int DEPTH  = 1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_resp_if bus();
  mem_resp dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int checks = 0;
  int errors = 0;

  logic [511:0] mm [DEPTH];
  logic         m_busy, m_rv, m_wd;
  logic [511:0] m_blk;
  longint       e, a_end;
  bit           k_wr;
  int           k_idx;
  logic [511:0] k_blk;

  function automatic logic [511:0] init_blk(int i);
    logic [511:0] b = '0;
`ifdef MEM_RESP_INIT_PATTERN_EN
    for (int w = 0; w < 16; w++) b[w*32 +: 32] = 32'(i * 64 + w * 4);
`endif
    return b;
  endfunction

  task automatic chk(string nm, logic [511:0] act, logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: request accepted at edge A completes at edge A+LAT, busy through edge A+LAT,
  // next acceptance possible from edge A+LAT+2.
  initial begin
    for (int i = 0; i < DEPTH; i++) mm[i] = init_blk(i);
    e = 0; a_end = -10; m_busy = 0; m_rv = 0; m_wd = 0; m_blk = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        a_end = -10; m_busy = 0; m_rv = 0; m_wd = 0; m_blk = '0;
      end
      chk("busy", 512'(bus.busy), 512'(m_busy));
      chk("rd_valid", 512'(bus.rd_valid), 512'(m_rv));
      chk("wr_done", 512'(bus.wr_done), 512'(m_wd));
      chk("mem_rd_blk", bus.mem_rd_blk, m_blk);
      e++;
      if (!rst) begin
        m_rv = 0; m_wd = 0;
        if (e == a_end) begin
          if (k_wr) begin mm[k_idx] = k_blk; m_wd = 1; end
          else begin m_blk = mm[k_idx]; m_rv = 1; end
        end
        if (e >= a_end + 2 && (bus.mem_wr_en || bus.mem_rd_en)) begin
          k_wr  = bus.mem_wr_en;
          k_idx = int'(bus.mem_addr[15:6]);
          k_blk = bus.mem_wr_blk;
          a_end = e + (k_wr ? WR_LAT : RD_LAT);
        end
        m_busy = e <= a_end;
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!bus.busy) return;
    end
    errors++;
    $display("FAIL wait_idle: busy stuck high");
  endtask

  task automatic req(input logic [31:0] a, input bit rd, input bit wr, input logic [511:0] b,
                     output int lat, output logic [511:0] data, output bit rv, output bit wd);
    wait_idle();
    @(posedge clk); #1;
    bus.mem_addr = a; bus.mem_rd_en = rd; bus.mem_wr_en = wr; bus.mem_wr_blk = b;
    @(posedge clk); #1;
    bus.mem_rd_en = 0; bus.mem_wr_en = 0;
    lat = -1; data = '0; rv = 0; wd = 0;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (bus.rd_valid || bus.wr_done) begin
        lat = n - 1; data = bus.mem_rd_blk; rv = bus.rd_valid; wd = bus.wr_done;
        return;
      end
    end
    errors++;
    $display("FAIL req_timeout: no completion pulse for address %h", a);
  endtask

  initial begin
    int lat;
    logic [511:0] d, x;
    bit rv, wd;
    logic [511:0] fa;
    fa = {16{32'hfafa_fafa}};
    rst = 0;
    bus.mem_addr = '0; bus.mem_rd_en = 0; bus.mem_wr_en = 0; bus.mem_wr_blk = '0;
    #2 rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset_busy", 512'(bus.busy), 512'(0));

    req(32'h2000, 1, 0, '0, lat, d, rv, wd);
    chk("rd_lat", 512'(lat), 512'(4));
    chk("rd_pulse", 512'(rv), 512'(1));
`ifdef MEM_RESP_INIT_PATTERN_EN
    chk("rd_word0", 512'(d[31:0]), 512'(32'h0000_2000));
    chk("rd_word15", 512'(d[511:480]), 512'(32'h0000_203C));
`else
    chk("rd_word0", 512'(d[31:0]), 512'(32'h0));
    chk("rd_word15", 512'(d[511:480]), 512'(32'h0));
`endif
    @(negedge clk);
    chk("busy_after_done", 512'(bus.busy), 512'(0));

    req(32'h4000, 0, 1, fa, lat, d, rv, wd);
    chk("wr_lat", 512'(lat), 512'(6));
    chk("wr_pulse", 512'(wd), 512'(1));
    req(32'h4000, 1, 0, '0, lat, d, rv, wd);
    chk("rd_after_wr", d, fa);

    req(32'h6000, 1, 1, {16{32'h1234_5678}}, lat, d, rv, wd);
    chk("both_wr_done", 512'(wd), 512'(1));
    chk("both_rd_valid", 512'(rv), 512'(0));

    x = {16{32'h0bad_cafe}} ^ 512'h1;
    req(32'h1_0000, 0, 1, x, lat, d, rv, wd);
    req(32'h0000, 1, 0, '0, lat, d, rv, wd);
    chk("wrap_rd0", d, x);
    req(32'h0004, 1, 0, '0, lat, d, rv, wd);
    chk("wrap_rd4", d, x);

    wait_idle();
    @(posedge clk); #1;
    bus.mem_addr = 32'h2000; bus.mem_rd_en = 1;
    @(posedge clk); #1;
    bus.mem_rd_en = 0; bus.mem_addr = 32'h8000; bus.mem_wr_blk = {16{32'hdead_beef}};
    rv = 0;
    for (int n = 0; n < 50 && !rv; n++) begin
      bus.mem_wr_en = ~bus.mem_wr_en;
      @(negedge clk);
      rv = bus.rd_valid; d = bus.mem_rd_blk;
      @(posedge clk); #1;
    end
    bus.mem_wr_en = 0;
    chk("hold_pulse", 512'(rv), 512'(1));
`ifdef MEM_RESP_INIT_PATTERN_EN
    chk("hold_word0", 512'(d[31:0]), 512'(32'h0000_2000));
`else
    chk("hold_word0", 512'(d[31:0]), 512'(32'h0));
`endif

    wait_idle();
    @(posedge clk); #1;
    bus.mem_addr = 32'h4000; bus.mem_wr_en = 1; bus.mem_wr_blk = {16{32'h5555_aaaa}};
    @(posedge clk); #1;
    bus.mem_wr_en = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    chk("rst_busy", 512'(bus.busy), 512'(0));
    chk("rst_wr_done", 512'(bus.wr_done), 512'(0));
    chk("rst_blk", bus.mem_rd_blk, '0);
    @(posedge clk); #1;
    rst = 0;
    req(32'h4000, 1, 0, '0, lat, d, rv, wd);
    chk("rst_keeps_array", d, fa);

    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      rst = ($urandom % 150) == 0;
      bus.mem_rd_en = ($urandom % 3) == 0;
      bus.mem_wr_en = ($urandom % 4) == 0;
      bus.mem_addr = ($urandom & 32'h0003_0000) | (32'($urandom_range(0, 7)) << 6) | ($urandom & 32'h3f);
      for (int w = 0; w < 16; w++) bus.mem_wr_blk[w*32 +: 32] = $urandom;
    end
    @(posedge clk); #1;
    rst = 0; bus.mem_rd_en = 0; bus.mem_wr_en = 0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
